// File: rtl/sar_search_ctrl_pkg.sv
// rtl/sar_search_ctrl_pkg.sv - shared types and constants for the SAR search controller
package sar_search_ctrl_pkg;

  // Default operand width; matches the 4-bit magnitude comparator partner.
  localparam int DEFAULT_WIDTH = 4;

  // Controller states: wait for start, resolve one bit per cycle, signal completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sar_search_ctrl.sv
// rtl/sar_search_ctrl.sv - successive-approximation search controller driving a magnitude comparator
module sar_search_ctrl
  import sar_search_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             equal,
  input  logic             bigger,
  input  logic             less,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MSB_ONE = WIDTH'(1) << (WIDTH - 1);
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             flags_onehot;
  logic [WIDTH-1:0] guess_bit0_clr;

  // Exactly one of the three comparator flags must be set for a trustworthy answer.
  assign flags_onehot = (equal ^ bigger ^ less) & ~(equal & bigger & less);

  // Candidate with the LSB dropped, used when the last bit resolves as "less".
  assign guess_bit0_clr = guess_q & ~WIDTH'(1);

  // State and datapath registers; reset returns every output to zero immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      guess_q   <= '0;
      result_q  <= '0;
      bit_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      guess_q   <= guess_d;
      result_q  <= result_d;
      bit_idx_q <= bit_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: one comparator decision per SCAN cycle, MSB first.
  always_comb begin
    state_d   = state_q;
    guess_d   = guess_q;
    result_d  = result_q;
    bit_idx_d = bit_idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          guess_d   = MSB_ONE;
          bit_idx_d = TOP_IDX;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = SCAN;
        end
      end

      SCAN: begin
        if (!flags_onehot) begin
          // Comparator answer is contradictory; keep the previous result.
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (equal) begin
          result_d = guess_q;
          done_d   = 1'b1;
          state_d  = DONE;
        end else if (bit_idx_q == '0) begin
          // Last bit: "less" means A is the candidate with bit 0 cleared;
          // "bigger" here is impossible for a stable A.
          if (less) begin
            result_d = guess_bit0_clr;
          end else begin
            err_d = 1'b1;
          end
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          if (less) begin
            guess_d[bit_idx_q] = 1'b0;
          end
          guess_d[bit_idx_q - IDX_W'(1)] = 1'b1;
          bit_idx_d = bit_idx_q - IDX_W'(1);
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        guess_d = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        guess_d = '0;
      end
    endcase
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb/tb_sar_search_ctrl.sv - directed closed-loop bench for sar_search_ctrl
module tb_sar_search_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       equal;
  logic       bigger;
  logic       less;
  logic [3:0] guess;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       err;

  logic [3:0] a_val;
  logic       force_bad;
  int         n_checks;
  int         n_pass;

  sar_search_ctrl #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .equal  (equal),
    .bigger (bigger),
    .less   (less),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  // Comparator partner with B tied to guess; force_bad makes equal and bigger both high.
  assign equal  = force_bad ? 1'b1 : (a_val == guess);
  assign bigger = force_bad ? 1'b1 : (a_val > guess);
  assign less   = force_bad ? 1'b0 : (a_val < guess);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Launch a search for A and follow it cycle by cycle; gs packs expected guesses MSB-first.
  task automatic search(input logic [3:0] a, input logic [15:0] gs, input int k,
                        input logic [3:0] res, input logic e, input int pulse);
    a_val = a;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int i = 1; i <= k; i++) begin
      start = (i == pulse);
      check($sformatf("a%0d_guess_c%0d", a, i), guess, gs[15 - 4 * (i - 1) -: 4]);
      check($sformatf("a%0d_busy_c%0d", a, i), busy, 1'b1);
      check($sformatf("a%0d_done_c%0d", a, i), done, 1'b0);
      next_cycle();
    end
    start = 1'b0;
    check($sformatf("a%0d_done_pulse", a), done, 1'b1);
    check($sformatf("a%0d_busy_at_done", a), busy, 1'b1);
    check($sformatf("a%0d_result", a), result, res);
    check($sformatf("a%0d_err", a), err, e);
    next_cycle();
    check($sformatf("a%0d_done_low", a), done, 1'b0);
    check($sformatf("a%0d_busy_low", a), busy, 1'b0);
    check($sformatf("a%0d_guess_idle", a), guess, 4'h0);
    check($sformatf("a%0d_result_held", a), result, res);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a_val     = 4'h0;
    force_bad = 1'b0;
    #2;
    check("rst_guess", guess, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 4'h0);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // A=8: equal on the first guess
    search(4'd8, 16'h8000, 1, 4'd8, 1'b0, 0);
    // A=0: every guess is less
    search(4'd0, 16'h8421, 4, 4'd0, 1'b0, 0);
    // A=15: bigger three times then equal
    search(4'd15, 16'h8CEF, 4, 4'd15, 1'b0, 0);
    // A=5: less, bigger, less, equal
    search(4'd5, 16'h8465, 4, 4'd5, 1'b0, 0);

    // Contradictory flags: err set, result keeps 5
    force_bad = 1'b1;
    search(4'd9, 16'h8000, 1, 4'd5, 1'b1, 0);
    force_bad = 1'b0;

    // A=10 with a start pulse while busy; err from the previous search clears
    search(4'd10, 16'h8CA0, 3, 4'd10, 1'b0, 2);

    // Reset in the middle of a scan
    a_val = 4'd0;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    check("mid_guess_before_rst", guess, 4'h4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_guess", guess, 4'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_result", result, 4'h0);
    check("mid_rst_err", err, 1'b0);
    next_cycle();
    check("mid_rst_no_done", done, 1'b0);
    rst_n = 1'b1;
    next_cycle();
    check("post_rst_idle_busy", busy, 1'b0);

    // A=3 after reset: less, less, bigger, equal
    search(4'd3, 16'h8423, 4, 4'd3, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
